board_io_ctrl: RTL and testbench

Parametrised on-board user-I/O controller for the Marsohod2 top level: debounces NKEYS push-buttons and drives NLEDS LEDs with per-channel off/on/PWM/blink modes. It replaces direct wiring of keys and led at the top, and gives software-visible key events and LED control through a simple register-write strobe. It also exports a shared 1 ms tick.

---
 rtl/board_io_pkg.sv | 18 +
 rtl/board_io_key_debounce.sv | 50 +++++
 rtl/board_io_ctrl.sv | 147 ++++++++++++++
 tb/tb_board_io_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared types and helpers for the on-board key/LED controller.
package board_io_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_t;

    // Clocks per millisecond, never less than one so the prescaler stays legal.
    function automatic int tick_div(input int clk_hz);
        int d;
        d = clk_hz / 1000;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/board_io_key_debounce.sv
// One key: 2-FF synchroniser, ms-based debounce, press/release pulses; no backpressure.
// Event latency 2 clk + (DEBOUNCE_MS-1 .. DEBOUNCE_MS) ms; pulses coincide with key_state update.
module key_debounce #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1ms,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // key_in is already normalised (1 = pressed), so the released level is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (sync2 == key_state) begin
                cnt <= '0;
            end else if (tick_1ms) begin
                if (cnt == CW'(DEBOUNCE_MS - 1)) begin
                    cnt         <= '0;
                    key_state   <= sync2;
                    key_press   <= sync2;
                    key_release <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// User I/O: debounced keys, per-LED off/on/pwm/blink, shared 1 ms tick; no backpressure.
// Config writes show on led one clk later; key events per key_debounce latency.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int CLK_HZ         = 100000000,
    parameter int NKEYS          = 2,
    parameter int NLEDS          = 4,
    parameter int DEBOUNCE_MS    = 10,
    parameter int PWM_BITS       = 8,
    parameter int BLINK_BITS     = 10,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NKEYS-1:0]                           keys_raw,
    output logic [NKEYS-1:0]                           key_state,
    output logic [NKEYS-1:0]                           key_press,
    output logic [NKEYS-1:0]                           key_release,
    input  logic                                       led_wr,
    input  logic [((NLEDS > 1) ? $clog2(NLEDS) : 1)-1:0] led_sel,
    input  logic [1:0]                                 led_mode,
    input  logic [PWM_BITS-1:0]                        led_duty,
    input  logic [BLINK_BITS-1:0]                      led_period,
    output logic [NLEDS-1:0]                           led,
    output logic                                       tick_1ms
);

    localparam int DIV   = tick_div(CLK_HZ);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SEL_W = (NLEDS > 1) ? $clog2(NLEDS) : 1;
    localparam logic [SEL_W:0] NLEDS_W = (SEL_W + 1)'(NLEDS);

    // ---------------- 1 ms prescaler ----------------
    logic [PRE_W-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            tick_1ms <= 1'b0;
        end else if (pre_cnt == PRE_W'(DIV - 1)) begin
            pre_cnt  <= '0;
            tick_1ms <= 1'b1;
        end else begin
            pre_cnt  <= pre_cnt + 1'b1;
            tick_1ms <= 1'b0;
        end
    end

    // ---------------- keys ----------------
    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_key (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_1ms    (tick_1ms),
            .key_in      (keys_raw[k] ^ (KEY_ACTIVE_LOW != 0)),
            .key_state   (key_state[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k])
        );
    end

    // ---------------- LEDs ----------------
    led_mode_t             mode_q   [NLEDS];
    led_mode_t             mode_n   [NLEDS];
    logic [PWM_BITS-1:0]   duty_q   [NLEDS];
    logic [PWM_BITS-1:0]   duty_n   [NLEDS];
    logic [BLINK_BITS-1:0] period_q [NLEDS];
    logic [BLINK_BITS-1:0] period_n [NLEDS];
    logic [BLINK_BITS-1:0] bcnt_q   [NLEDS];
    logic [BLINK_BITS-1:0] bcnt_n   [NLEDS];
    logic [BLINK_BITS-1:0] blink_last;
    logic [NLEDS-1:0]      phase_q;
    logic [NLEDS-1:0]      phase_n;
    logic [NLEDS-1:0]      lit_q;
    logic [NLEDS-1:0]      lit_n;
    logic [PWM_BITS-1:0]   pwm_q;
    logic [PWM_BITS-1:0]   pwm_n;
    logic                  wr_hit;

    assign wr_hit = led_wr && ({1'b0, led_sel} < NLEDS_W);

    // lit is derived from next-state config so the registered output tracks a write in one clk.
    always_comb begin
        pwm_n      = pwm_q + 1'b1;
        mode_n     = mode_q;
        duty_n     = duty_q;
        period_n   = period_q;
        bcnt_n     = bcnt_q;
        phase_n    = phase_q;
        lit_n      = '0;
        blink_last = '0;
        for (int i = 0; i < NLEDS; i++) begin
            blink_last = (period_q[i] == '0) ? '0 : period_q[i] - 1'b1;
            if (tick_1ms) begin
                if (bcnt_q[i] == blink_last) begin
                    bcnt_n[i]  = '0;
                    phase_n[i] = ~phase_q[i];
                end else begin
                    bcnt_n[i] = bcnt_q[i] + 1'b1;
                end
            end
            // A write overrides a coincident blink toggle.
            if (wr_hit && (led_sel == SEL_W'(i))) begin
                mode_n[i]   = led_mode_t'(led_mode);
                duty_n[i]   = led_duty;
                period_n[i] = led_period;
                bcnt_n[i]   = '0;
                phase_n[i]  = 1'b1;
            end
            case (mode_n[i])
                LED_ON:    lit_n[i] = 1'b1;
                LED_PWM:   lit_n[i] = (duty_n[i] == '1) || (pwm_n < duty_n[i]);
                LED_BLINK: lit_n[i] = phase_n[i];
                default:   lit_n[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q   <= '0;
            phase_q <= '0;
            lit_q   <= '0;
            for (int i = 0; i < NLEDS; i++) begin
                mode_q[i]   <= LED_OFF;
                duty_q[i]   <= '0;
                period_q[i] <= '0;
                bcnt_q[i]   <= '0;
            end
        end else begin
            pwm_q    <= pwm_n;
            phase_q  <= phase_n;
            lit_q    <= lit_n;
            mode_q   <= mode_n;
            duty_q   <= duty_n;
            period_q <= period_n;
            bcnt_q   <= bcnt_n;
        end
    end

    assign led = lit_q ^ {NLEDS{(LED_ACTIVE_LOW != 0)}};

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: 10-clk tick, 3 ms debounce, 5 LEDs (so out-of-range selects exist).
module tb_board_io_ctrl;
    import board_io_pkg::*;

    localparam int NK = 2;
    localparam int NL = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NK-1:0]   keys_raw = '1;
    logic [NK-1:0]   key_state, key_press, key_release;
    logic            led_wr = 1'b0;
    logic [2:0]      led_sel = '0;
    logic [1:0]      led_mode = '0;
    logic [7:0]      led_duty = '0;
    logic [9:0]      led_period = '0;
    logic [NL-1:0]   led;
    logic            tick_1ms;

    int n_chk  = 0;
    int n_fail = 0;

    board_io_ctrl #(
        .CLK_HZ(10000), .NKEYS(NK), .NLEDS(NL), .DEBOUNCE_MS(3),
        .PWM_BITS(8), .BLINK_BITS(10), .KEY_ACTIVE_LOW(1), .LED_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .key_state(key_state),
        .key_press(key_press), .key_release(key_release), .led_wr(led_wr),
        .led_sel(led_sel), .led_mode(led_mode), .led_duty(led_duty),
        .led_period(led_period), .led(led), .tick_1ms(tick_1ms)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] duty;
        logic [9:0] period;
        logic [4:0] exp_led;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Drives a one-clk write; returns at the first sample after the write edge.
    task automatic led_write(input logic [2:0] sel, input logic [1:0] mode,
                             input logic [7:0] duty, input logic [9:0] period);
        led_sel = sel; led_mode = mode; led_duty = duty; led_period = period;
        led_wr = 1'b1;
        cyc();
        led_wr = 1'b0;
    endtask

    task automatic wait_led1_change(input int budget, output int n, output bit ok);
        logic v;
        v  = led[1];
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            cyc();
            n++;
            if (led[1] !== v) ok = 1'b1;
        end
    endtask

    task automatic count_led2(input int len, output int lit);
        lit = 0;
        for (int i = 0; i < len; i++) begin
            cyc();
            if (led[2]) lit++;
        end
    endtask

    initial begin
        int  n, cnt, pulses;
        bit  ok;

        vecs[0] = '{3'd0, LED_ON,    8'd0,   10'd0,  5'b00001};
        vecs[1] = '{3'd3, LED_ON,    8'd0,   10'd0,  5'b01001};
        vecs[2] = '{3'd2, LED_PWM,   8'd255, 10'd0,  5'b01101};
        vecs[3] = '{3'd4, LED_PWM,   8'd0,   10'd0,  5'b01101};
        vecs[4] = '{3'd3, LED_OFF,   8'd0,   10'd0,  5'b00101};
        vecs[5] = '{3'd5, LED_ON,    8'd0,   10'd0,  5'b00101};
        vecs[6] = '{3'd7, LED_BLINK, 8'd0,   10'd1,  5'b00101};
        vecs[7] = '{3'd4, LED_ON,    8'd0,   10'd0,  5'b10101};
        vecs[8] = '{3'd0, LED_OFF,   8'd0,   10'd0,  5'b10100};
        vecs[9] = '{3'd1, LED_BLINK, 8'd0,   10'd50, 5'b10110};

        // Reset values and tick cadence.
        repeat (3) cyc();
        check("rst_led", led, 0);
        check("rst_key_state", key_state, 0);
        check("rst_press", key_press, 0);
        check("rst_release", key_release, 0);
        check("rst_tick", tick_1ms, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            cyc();
            check($sformatf("tick_at_%0d", k), tick_1ms, (k % 10) == 0);
        end
        check("no_spurious_key", key_state | key_press | key_release, 0);

        // LED configuration table.
        for (int i = 0; i < 10; i++) begin
            led_write(vecs[i].sel, vecs[i].mode, vecs[i].duty, vecs[i].period);
            check($sformatf("led_vec%0d", i), led, vecs[i].exp_led);
        end

        // PWM duty cycles over one full counter period.
        led_write(3'd2, LED_PWM, 8'd64, 10'd0);
        count_led2(256, cnt);
        check("pwm_duty64", cnt, 64);
        led_write(3'd2, LED_PWM, 8'd255, 10'd0);
        count_led2(256, cnt);
        check("pwm_duty255", cnt, 256);
        led_write(3'd2, LED_PWM, 8'd0, 10'd0);
        count_led2(256, cnt);
        check("pwm_duty0", cnt, 0);

        // Blink with 2 ms half-period.
        led_write(3'd1, LED_BLINK, 8'd0, 10'd2);
        check("blink_first_lit", led[1], 1);
        wait_led1_change(25, n, ok);
        check("blink_first_toggle", ok && n >= 11 && n <= 20, 1);
        wait_led1_change(25, n, ok);
        check("blink_rise_interval", ok ? n : -1, 20);
        wait_led1_change(25, n, ok);
        check("blink_fall_interval", ok ? n : -1, 20);
        wait_led1_change(25, n, ok);
        check("blink_rise2_interval", ok ? n : -1, 20);
        // Rewrite on the tick that would turn the LED off.
        repeat (19) cyc();
        check("blink_tick_aligned", tick_1ms, 1);
        led_write(3'd1, LED_BLINK, 8'd0, 10'd2);
        check("blink_write_wins", led[1], 1);
        wait_led1_change(25, n, ok);
        check("blink_restart_interval", ok ? n : -1, 20);

        // Clean press and release on key 0.
        keys_raw[0] = 1'b0;
        n = 0; ok = 1'b0; pulses = 0;
        while (n < 60 && !ok) begin
            cyc();
            n++;
            if (key_release[0]) pulses++;
            if (key_press[0]) ok = 1'b1;
        end
        check("press_seen", ok, 1);
        check("press_latency_ok", n >= 22 && n <= 32, 1);
        check("press_state", key_state[0], 1);
        cyc();
        check("press_one_clk", key_press[0], 0);
        repeat (40) begin
            cyc();
            if (key_press[0] || key_release[0]) pulses++;
        end
        check("press_hold_no_events", pulses, 0);
        keys_raw[0] = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 60 && !ok) begin
            cyc();
            n++;
            if (key_release[0]) ok = 1'b1;
        end
        check("release_seen", ok, 1);
        check("release_latency_ok", n >= 22 && n <= 32, 1);
        check("release_state", key_state[0], 0);

        // Bouncing key 1: no accepted event.
        pulses = 0;
        for (int t = 0; t < 100; t++) begin
            cyc();
            if (key_press[1] || key_release[1]) pulses++;
            if (t % 7 == 0) keys_raw[1] = ~keys_raw[1];
        end
        keys_raw[1] = 1'b1;
        repeat (50) begin
            cyc();
            if (key_press[1] || key_release[1]) pulses++;
        end
        check("bounce_no_events", pulses, 0);
        check("bounce_state", key_state[1], 0);

        // Reset pulse mid-debounce.
        keys_raw[0] = 1'b0;
        repeat (15) cyc();
        check("mid_debounce_state", key_state[0], 0);
        check("pre_reset_led_nonzero", led != 0, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_keys", key_state, 0);
        check("async_rst_tick", tick_1ms, 0);
        keys_raw[0] = 1'b1;
        cyc();
        rst_n = 1'b1;
        pulses = 0;
        repeat (60) begin
            cyc();
            if (key_press != 0 || key_release != 0) pulses++;
        end
        check("post_reset_no_events", pulses, 0);
        check("post_reset_state", key_state, 0);
        check("post_reset_led", led, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
